// File: rtl/pwm_dac_pkg.sv
// Shared types and constants for the PWM DAC block.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_dac_pkg;

    localparam int DEF_CODE_WIDTH        = 10;
    localparam int DEF_CYCLES_PER_WINDOW = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwm_window_counter.sv
// Free-running PWM window position counter with request and wrap ticks.
// Latency: ticks are decoded combinationally from the registered count.
// Backpressure: none; holds at zero while run is low.
module pwm_window_counter
    import pwm_dac_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = DEF_CYCLES_PER_WINDOW,
    parameter int CW                = cnt_width(CYCLES_PER_WINDOW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic          req_tick,
    output logic          last_tick
);

    localparam logic [CW-1:0] REQ_VAL  = CW'(CYCLES_PER_WINDOW - 2);
    localparam logic [CW-1:0] LAST_VAL = CW'(CYCLES_PER_WINDOW - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        req_tick  = (cnt_q == REQ_VAL);
        last_tick = (cnt_q == LAST_VAL);
        cnt_d     = '0;
        if (run && !last_tick) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_dac.sv
// Sample-code to 1-bit PWM converter, one freshly requested sample per window.
// Latency: code to pwm 1 cycle for the first window; pwm registered, aligned to cnt.
// Backpressure: none; code sampled blindly. PWM_CENTER_ALIGN_EN centres the pulse.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = DEF_CYCLES_PER_WINDOW,
    parameter int CODE_WIDTH        = DEF_CODE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CODE_WIDTH-1:0] code,
    output logic                  next_sample,
    output logic                  pwm,
    output logic                  active
);

    localparam int CW    = cnt_width(CYCLES_PER_WINDOW);
    localparam int CMP_W = max_int(CODE_WIDTH, CW + 1) + 1;
    localparam logic [CMP_W-1:0] WIN_LEN = CMP_W'(CYCLES_PER_WINDOW);

    state_e                state_q;
    state_e                state_d;
    logic [CODE_WIDTH-1:0] duty_q;
    logic [CODE_WIDTH-1:0] duty_d;
    logic                  pwm_q;
    logic                  pwm_d;
    logic                  latch;
    logic                  hit;
    logic                  running;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  req_tick;
    logic                  last_tick;

    assign running = (state_q != IDLE);

    pwm_window_counter #(
        .CYCLES_PER_WINDOW(CYCLES_PER_WINDOW),
        .CW               (CW)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .run      (running),
        .cnt      (cnt),
        .req_tick (req_tick),
        .last_tick(last_tick)
    );

    // Look-ahead count lets the registered pwm line up with cnt itself.
    assign cnt_nxt = (running && !last_tick) ? cnt + CW'(1) : '0;

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    latch   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (last_tick) begin
                    if (enable) begin
                        state_d = RUN;
                        latch   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = enable ? RUN : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        duty_d = latch ? code : duty_q;
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic [CMP_W-1:0] duty_sat;
    logic [CMP_W-1:0] off_q;
    logic [CMP_W-1:0] off_d;

    always_comb begin
        duty_sat = (CMP_W'(duty_d) > WIN_LEN) ? WIN_LEN : CMP_W'(duty_d);
        off_d    = latch ? ((WIN_LEN - duty_sat) >> 1) : off_q;
        hit      = (CMP_W'(cnt_nxt) >= off_d) && (CMP_W'(cnt_nxt) < (off_d + duty_sat));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end
`else
    // Codes beyond the window length saturate naturally: cnt never reaches them.
    always_comb begin
        hit = (CMP_W'(cnt_nxt) < CMP_W'(duty_d));
    end
`endif

    assign pwm_d = (state_d != IDLE) && hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm         = pwm_q;
    assign active      = running;
    assign next_sample = running && req_tick;

endmodule

// File: doc/pwm_dac.md
Name: pwm_dac

Overview:
- Consumer end of the code/next_sample sample interface; converts the oscillator's 10-bit sample code into a 1-bit PWM stream for the board audio/DAC pin.
- Runs fixed-length PWM windows, one sample per window.
- Requests each new sample with a single-cycle next_sample pulse, timed so the fresh code is latched before the next window starts.

Parameters:
- CYCLES_PER_WINDOW, 1024, clock cycles per PWM window (>= 4); counter width = $clog2(CYCLES_PER_WINDOW).
- CODE_WIDTH, 10, width of the incoming sample code.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- enable  in  1  level; 1 = run PWM windows, 0 = stop after the current window.
- code  in  CODE_WIDTH  sample from the oscillator; valid from the cycle after next_sample.
- next_sample  out  1  single-cycle request to advance the oscillator.
- pwm  out  1  PWM output.
- active  out  1  high while a window is in progress.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, duty=0, pwm=0, next_sample=0, active=0. The reset takes effect immediately, including mid-window; pwm drops without waiting for the window to end.
- State IDLE: pwm=0 and next_sample=0. When enable=1, latch duty<=code, set cnt<=0, and go to RUN. A code-to-pwm latency of 1 cycle applies to the first window.
- State RUN: cnt increments by 1 per cycle and wraps from CYCLES_PER_WINDOW-1 to 0.
  - pwm (registered) = 1 when cnt < duty.
  - active=1.
- next_sample: asserted for exactly one cycle when cnt == CYCLES_PER_WINDOW-2.
- Duty latch: at the edge where cnt == CYCLES_PER_WINDOW-1, duty<=code. This captures the code updated by the preceding request, so each window uses a freshly requested sample. Exactly one next_sample is issued per completed window.
- Saturation: code >= CYCLES_PER_WINDOW gives pwm=1 for the whole window. code=0 gives pwm=0 for the whole window.
- Comparison is unsigned with zero-extension to max(CODE_WIDTH, counter width).
- enable falls during RUN: go to DRAIN.
  - The current window finishes unchanged.
  - next_sample is still issued at cnt == CYCLES_PER_WINDOW-2, so the oscillator phase stays consistent.
  - At wrap the block goes to IDLE and does not latch duty.
- enable returns to 1 during DRAIN: go back to RUN with no gap; the window continues as if enable never dropped.
- Simultaneous wrap and enable=0: the enable value sampled on the wrap edge decides. 0 means IDLE; 1 means continue RUN.
- No back-pressure: code is sampled blindly. The source must present a valid code one cycle after next_sample.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- Defined: pwm=1 when off <= cnt < off+duty_sat, where duty_sat = min(duty, CYCLES_PER_WINDOW) and off = (CYCLES_PER_WINDOW-duty_sat)>>1 is computed at the duty latch. The pulse is centred in the window. High-cycle count per window is unchanged.
- Undefined: left-aligned pulse (cnt < duty). No off register is built.
- next_sample timing is identical in both builds.

Decomposition:
- Package pwm_dac_pkg holds:
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - the default CODE_WIDTH and CYCLES_PER_WINDOW constants;
  - a function for the counter width.
- One sub-module, pwm_window_counter: the wrapping counter, with outputs cnt, req_tick (cnt==N-2) and last_tick (cnt==N-1).
- The FSM, duty/off registers and comparator stay in pwm_dac.

Test Plan (bench uses CYCLES_PER_WINDOW=8, CODE_WIDTH=10, NCO model advancing on next_sample):
- Reset: hold rst=0 with enable=1 and code=5 -> pwm=0, next_sample=0, active=0. Drop rst mid-window -> pwm goes 0 the same cycle, with no clock needed.
- Steady state: codes 3 then 6 -> windows show 3 then 6 high cycles. next_sample pulses at cnt=6 only, exactly once per 8 cycles.
- Boundaries: code=0 -> pwm never high. code=8 -> 8/8 high. code=1023 -> 8/8 high (saturated), with no glitch at wrap.
- Stop/restart: enable=0 at cnt=2 -> window completes, one more next_sample at cnt=6, then IDLE with pwm=0. enable=1 again -> first window uses the current code.
- DRAIN cancel: enable 0 then back to 1 before wrap -> no idle gap, pulse train continues, next_sample period remains 8.
- PWM_CENTER_ALIGN_EN defined, code=4 -> pwm high at cnt 2..5. code=3 -> high at cnt 2..4. next_sample still at cnt=6.
